// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and a DMA requester.
// One access in flight; req/gnt/done handshake; read data captured after RD_LAT cycles.
module mem_port_arbiter #(
    parameter int AW     = 12,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          mclk,
    input  logic          mrst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_done,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    state_t     state;
    owner_t     owner;
    owner_t     last_owner;
    logic       owner_we;
    logic [2:0] lat_cnt;
    logic       pick_cpu;

    // On contention the requester that did not own the port last time wins.
    assign pick_cpu = cpu_req && (!dma_req || last_owner == OWN_DMA);

    always_ff @(posedge mclk) begin
        if (!mrst) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_DMA;
            owner_we   <= 1'b0;
            lat_cnt    <= 3'd0;
            cpu_gnt    <= 1'b0;
            dma_gnt    <= 1'b0;
            cpu_done   <= 1'b0;
            dma_done   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here so every state only has to raise them.
            cpu_done <= 1'b0;
            dma_done <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        owner      <= pick_cpu ? OWN_CPU : OWN_DMA;
                        last_owner <= pick_cpu ? OWN_CPU : OWN_DMA;
                        owner_we   <= pick_cpu ? cpu_we : dma_we;
                        mem_addr   <= pick_cpu ? cpu_addr : dma_addr;
                        mem_wdata  <= pick_cpu ? cpu_wdata : dma_wdata;
                        mem_en     <= 1'b1;
                        mem_we     <= pick_cpu ? cpu_we : dma_we;
                        cpu_gnt    <= pick_cpu;
                        dma_gnt    <= !pick_cpu;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (owner_we) begin
                        cpu_done <= (owner == OWN_CPU);
                        dma_done <= (owner == OWN_DMA);
                        state    <= DONE;
                    end else begin
                        lat_cnt <= LAT_INIT;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        rdata    <= mem_rdata;
                        cpu_done <= (owner == OWN_CPU);
                        dma_done <= (owner == OWN_DMA);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    cpu_gnt <= 1'b0;
                    dma_gnt <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (RD_LAT=3) with a latency-accurate memory read model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter;

    localparam int AW     = 12;
    localparam int DW     = 16;
    localparam int RD_LAT = 3;

    logic          mclk = 1'b0;
    logic          mrst;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic          cpu_gnt, cpu_done, dma_gnt, dma_done;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    logic [2:0]    rd_pipe = 3'b000;
    logic [DW-1:0] rd_value = 16'h0000;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .mclk(mclk), .mrst(mrst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 mclk = ~mclk;

    // Memory model: read data is valid only in the cycle RD_LAT cycles after the mem_en cycle.
    always @(posedge mclk) rd_pipe <= {rd_pipe[1:0], mem_en && !mem_we};
    assign mem_rdata = rd_pipe[RD_LAT-1] ? rd_value : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge mclk);
        #1;
    endtask

    initial begin
        mrst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

        // 1. Reset held 3 cycles with both requests high; CPU wins first tie.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h001; cpu_wdata = 16'h0001;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h002; dma_wdata = 16'h0002;
        cyc(); cyc(); cyc();
        check("rst_cpu_gnt", 32'(cpu_gnt), 0);
        check("rst_dma_gnt", 32'(dma_gnt), 0);
        check("rst_cpu_done", 32'(cpu_done), 0);
        check("rst_dma_done", 32'(dma_done), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_rdata", 32'(rdata), 0);
        mrst = 1'b1;
        cyc();
        check("t1_cpu_gnt", 32'(cpu_gnt), 1);
        check("t1_dma_gnt", 32'(dma_gnt), 0);
        check("t1_mem_addr", 32'(mem_addr), 32'h001);
        cyc();
        check("t1_cpu_done", 32'(cpu_done), 1);
        cyc();
        cpu_req = 1'b0; dma_req = 1'b0;

        // 2. CPU write 0x123 <- 0xBEEF; request seen in this IDLE cycle (c).
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 16'hBEEF;
        cyc();
        check("t2_mem_en", 32'(mem_en), 1);
        check("t2_mem_we", 32'(mem_we), 1);
        check("t2_mem_addr", 32'(mem_addr), 32'h123);
        check("t2_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        check("t2_cpu_gnt", 32'(cpu_gnt), 1);
        check("t2_dma_gnt_a", 32'(dma_gnt), 0);
        check("t2_busy", 32'(busy), 1);
        check("t2_done_early", 32'(cpu_done), 0);
        cyc();
        check("t2_cpu_done", 32'(cpu_done), 1);
        check("t2_mem_en_low", 32'(mem_en), 0);
        check("t2_dma_gnt_b", 32'(dma_gnt), 0);
        cyc();
        check("t2_done_once", 32'(cpu_done), 0);
        check("t2_idle_busy", 32'(busy), 0);
        cpu_req = 1'b0;

        // 3. DMA read with RD_LAT=3: done at c+5 carrying 0x5A5A.
        rd_value = 16'h5A5A;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h0AB;
        cyc();
        check("t3_mem_en", 32'(mem_en), 1);
        check("t3_mem_we", 32'(mem_we), 0);
        check("t3_dma_gnt", 32'(dma_gnt), 1);
        check("t3_cpu_gnt", 32'(cpu_gnt), 0);
        check("t3_mem_addr", 32'(mem_addr), 32'h0AB);
        for (int k = 2; k <= 4; k++) begin
            cyc();
            check($sformatf("t3_wait_mem_en_c%0d", k), 32'(mem_en), 0);
            check($sformatf("t3_wait_done_c%0d", k), 32'(dma_done), 0);
            check($sformatf("t3_wait_gnt_c%0d", k), 32'(dma_gnt), 1);
        end
        cyc();
        check("t3_dma_done", 32'(dma_done), 1);
        check("t3_rdata", 32'(rdata), 32'h5A5A);
        check("t3_cpu_done", 32'(cpu_done), 0);
        cyc();
        dma_req = 1'b0;
        check("t3_rdata_held", 32'(rdata), 32'h5A5A);
        check("t3_idle_busy", 32'(busy), 0);
        check("t3_idle_gnt", 32'(dma_gnt), 0);

        // 4. Continuous contention over 6 writes: strict alternation, 3-cycle period.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 16'h1010;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h020; dma_wdata = 16'h2020;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check($sformatf("t4_cpu_gnt_%0d", i), 32'(cpu_gnt), (i % 2 == 0) ? 1 : 0);
            check($sformatf("t4_dma_gnt_%0d", i), 32'(dma_gnt), (i % 2 == 0) ? 0 : 1);
            check($sformatf("t4_mem_addr_%0d", i), 32'(mem_addr), (i % 2 == 0) ? 32'h010 : 32'h020);
            check($sformatf("t4_mem_en_%0d", i), 32'(mem_en), 1);
            cyc();
            check($sformatf("t4_cpu_done_%0d", i), 32'(cpu_done), (i % 2 == 0) ? 1 : 0);
            check($sformatf("t4_dma_done_%0d", i), 32'(dma_done), (i % 2 == 0) ? 0 : 1);
            cyc();
            check($sformatf("t4_gap_busy_%0d", i), 32'(busy), 0);
            check($sformatf("t4_gap_done_%0d", i), 32'({cpu_done, dma_done}), 0);
        end
        cpu_req = 1'b0; dma_req = 1'b0;

        // 5. Reset during WAIT of a CPU read: no done, rdata cleared, new request served.
        rd_value = 16'h1111;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h055;
        cyc();
        check("t5_cpu_gnt", 32'(cpu_gnt), 1);
        cyc();
        check("t5_wait_busy", 32'(busy), 1);
        mrst = 1'b0;
        cyc();
        check("t5_rst_done", 32'(cpu_done), 0);
        check("t5_rst_gnt", 32'(cpu_gnt), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_mem_en", 32'(mem_en), 0);
        check("t5_rst_rdata", 32'(rdata), 0);
        cyc();
        check("t5_rst2_done", 32'(cpu_done), 0);
        mrst = 1'b1;
        cyc();
        check("t5_new_gnt", 32'(cpu_gnt), 1);
        check("t5_new_mem_en", 32'(mem_en), 1);
        check("t5_new_addr", 32'(mem_addr), 32'h055);
        cyc(); cyc(); cyc();
        check("t5_new_no_early_done", 32'(cpu_done), 0);
        cyc();
        check("t5_new_done", 32'(cpu_done), 1);
        check("t5_new_rdata", 32'(rdata), 32'h1111);
        cyc();
        cpu_req = 1'b0;

        // 6. cpu_req dropped in ACCESS: access completes, later IDLE sees nothing.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h077; cpu_wdata = 16'h7777;
        cyc();
        check("t6_gnt", 32'(cpu_gnt), 1);
        cpu_req = 1'b0; cpu_addr = 12'h0FF; cpu_wdata = 16'h0000;
        cyc();
        check("t6_done", 32'(cpu_done), 1);
        check("t6_addr_latched", 32'(mem_addr), 32'h077);
        check("t6_wdata_latched", 32'(mem_wdata), 32'h7777);
        cyc();
        check("t6_done_once", 32'(cpu_done), 0);
        check("t6_busy_idle", 32'(busy), 0);
        cyc();
        check("t6_no_regrant", 32'(cpu_gnt), 0);
        check("t6_no_mem_en", 32'(mem_en), 0);
        check("t6_still_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
